// File: rtl/sec_decoder_pkg.sv
// Shared widths and types for the seconds-to-decimal-digits decoder.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package sec_decoder_pkg;

    localparam int SEC_W  = 6;
    localparam int TENS_W = 3;
    localparam int ONES_W = 4;

    // Largest legal seconds value; anything above it is out of range.
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef logic [SEC_W-1:0]  sec_t;
    typedef logic [TENS_W-1:0] tens_t;
    typedef logic [ONES_W-1:0] ones_t;

endpackage

// File: rtl/sec_div10.sv
// Combinational divide-by-10 of a 6-bit seconds value into tens and ones digits.
// Latency: combinational, zero cycles.
// Backpressure: none; the result follows the input continuously.
// Optional: SEC_DECODER_RANGE_CHK_EN clamps 60..63 to 5/9 and raises err.
module sec_div10
    import sec_decoder_pkg::*;
(
    input  logic [SEC_W-1:0]  sec_in,
    output logic [TENS_W-1:0] tens,
`ifdef SEC_DECODER_RANGE_CHK_EN
    output logic              err,
`endif
    output logic [ONES_W-1:0] ones
);

    // The remainder is always below 10, so it fits in the low nibble.
    // That means the subtraction only needs the low nibble of the
    // operands: (sec_in - 10*k) mod 16 equals the true remainder.
    ones_t sub_lo;
    tens_t quo;

    // Compare/subtract ladder picking the largest multiple of ten <= sec_in.
    always_comb begin
        quo    = 3'd0;
        sub_lo = 4'd0;
        if (sec_in >= 6'd60) begin
            quo    = 3'd6;
            sub_lo = 4'(6'd60);
        end else if (sec_in >= 6'd50) begin
            quo    = 3'd5;
            sub_lo = 4'(6'd50);
        end else if (sec_in >= 6'd40) begin
            quo    = 3'd4;
            sub_lo = 4'(6'd40);
        end else if (sec_in >= 6'd30) begin
            quo    = 3'd3;
            sub_lo = 4'(6'd30);
        end else if (sec_in >= 6'd20) begin
            quo    = 3'd2;
            sub_lo = 4'(6'd20);
        end else if (sec_in >= 6'd10) begin
            quo    = 3'd1;
            sub_lo = 4'(6'd10);
        end
    end

`ifdef SEC_DECODER_RANGE_CHK_EN
    // Out-of-range seconds saturate to the largest displayable value.
    always_comb begin
        err  = (sec_in > SEC_MAX);
        tens = quo;
        ones = sec_in[ONES_W-1:0] - sub_lo;
        if (err) begin
            tens = 3'd5;
            ones = 4'd9;
        end
    end
`else
    // Out-of-range seconds decode arithmetically (tens reaches 6).
    always_comb begin
        tens = quo;
        ones = sec_in[ONES_W-1:0] - sub_lo;
    end
`endif

endmodule

// File: rtl/sec_decoder.sv
// Registers the decimal tens/ones digits of a binary seconds count (0..59).
// Latency: one clk cycle from sec_in to tens/ones (and err).
// Backpressure: none; sec_in is sampled on every rising clk edge.
// Optional: SEC_DECODER_RANGE_CHK_EN adds the err port and range clamping.
module sec_decoder
    import sec_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SEC_W-1:0]  sec_in,
    output logic [TENS_W-1:0] tens,
`ifdef SEC_DECODER_RANGE_CHK_EN
    output logic              err,
`endif
    output logic [ONES_W-1:0] ones
);

    tens_t tens_nxt;
    ones_t ones_nxt;

`ifdef SEC_DECODER_RANGE_CHK_EN
    logic err_nxt;

    sec_div10 u_div (
        .sec_in (sec_in),
        .tens   (tens_nxt),
        .err    (err_nxt),
        .ones   (ones_nxt)
    );

    // Digits and the range flag register together from one sampled input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= 3'd0;
            ones <= 4'd0;
            err  <= 1'b0;
        end else begin
            tens <= tens_nxt;
            ones <= ones_nxt;
            err  <= err_nxt;
        end
    end
`else
    sec_div10 u_div (
        .sec_in (sec_in),
        .tens   (tens_nxt),
        .ones   (ones_nxt)
    );

    // Both digits register together from one sampled input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= 3'd0;
            ones <= 4'd0;
        end else begin
            tens <= tens_nxt;
            ones <= ones_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_sec_decoder.sv
// Self-checking bench for sec_decoder: directed boundaries, a full sweep,
// reset behaviour and random values compared against an arithmetic model.
// Follows SEC_DECODER_RANGE_CHK_EN to select the expected out-of-range result.
module tb_sec_decoder;

    logic       clk;
    logic       rst;
    logic [5:0] sec_in;
    logic [2:0] tens;
    logic [3:0] ones;
`ifdef SEC_DECODER_RANGE_CHK_EN
    logic       err;
`endif

    int compared   = 0;
    int mismatched = 0;

    sec_decoder dut (
        .clk    (clk),
        .rst    (rst),
        .sec_in (sec_in),
        .tens   (tens),
`ifdef SEC_DECODER_RANGE_CHK_EN
        .err    (err),
`endif
        .ones   (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain decimal arithmetic on the seconds value.
    function automatic void model(input int s, output int t, output int o, output int e);
`ifdef SEC_DECODER_RANGE_CHK_EN
        if (s > 59) begin
            t = 5; o = 9; e = 1;
        end else begin
            t = s / 10; o = s % 10; e = 0;
        end
`else
        t = s / 10; o = s % 10; e = 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int t, input int o, input int e);
        check({tag, ".tens"}, 32'(tens), 32'(t));
        check({tag, ".ones"}, 32'(ones), 32'(o));
`ifdef SEC_DECODER_RANGE_CHK_EN
        check({tag, ".err"}, 32'(err), 32'(e));
`else
        if (e != 0) check({tag, ".model_err"}, 32'(e), 32'd0);
`endif
    endtask

    // Drive v on the falling edge, check the registered result after the next rising edge.
    task automatic step(input string tag, input int v);
        int t, o, e;
        @(negedge clk);
        sec_in = 6'(v);
        @(posedge clk);
        #1;
        model(v, t, o, e);
        check_out($sformatf("%s[%0d]", tag, v), t, o, e);
    endtask

    initial begin
        int t, o, e;
        int pat[5];
        pat = '{0, 9, 10, 45, 59};

        // Reset held with a non-zero input across several edges.
        rst    = 1'b1;
        sec_in = 6'd37;
        #1;
        check_out("reset_t0", 0, 0, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_out("reset_hold", 0, 0, 0);
        end

        @(negedge clk);
        rst = 1'b0;

        // Directed boundaries.
        foreach (pat[i]) step("directed", pat[i]);

        // Full legal sweep.
        for (int v = 0; v < 60; v++) step("sweep", v);

        // Out-of-range inputs.
        step("oor", 60);
        step("oor", 63);

        // Reset asserted between edges clears outputs immediately.
        step("pre_rst", 42);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0);
        sec_in = 6'd17;
        @(negedge clk);
        check_out("rst_held", 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_rst[17]", 1, 7, 0);

        // Input change without an edge leaves outputs unchanged.
        step("hold_base", 23);
        @(negedge clk);
        sec_in = 6'd58;
        #3;
        check_out("hold_mid", 2, 3, 0);
        @(posedge clk);
        #1;
        model(58, t, o, e);
        check_out("hold_next[58]", t, o, e);

        // Random values across the full 6-bit input range.
        for (int n = 0; n < 60; n++) step("rand", int'($urandom_range(0, 63)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
